uart_rx: RTL and testbench

- Oversampling UART receiver: 8N1 framing, LSB first, idle line high.
- Sits downstream of the UART transmitter on the serial line and shares the same baud_sample_tick generator (OVERSAMPLE ticks per bit).
- Recovers bytes from the asynchronous rx pin and presents each one as a single-cycle valid pulse.
- Flags framing errors and overruns.

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx consumer-side bundle: received byte, status flags and read acknowledge.
// master = receiver, slave = downstream consumer.
interface uart_rx_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_error;
    logic       overrun;
    logic       rd_ack;

    modport master (
        output rx_byte,
        output rx_valid,
        output rx_busy,
        output frame_error,
        output overrun,
        input  rd_ack
    );

    modport slave (
        input  rx_byte,
        input  rx_valid,
        input  rx_busy,
        input  frame_error,
        input  overrun,
        output rd_ack
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver, LSB first, idle-high line.
// Start bit confirmed at mid-bit; data and stop sampled at bit centres.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    input  logic      baud_sample_tick,
    uart_rx_if.master bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] sample_cnt, sample_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift_reg, shift_reg_n;
    logic [7:0]    rx_byte_q, rx_byte_n;
    logic          valid_q, valid_n;
    logic          ferr_q, ferr_n;
    logic          pending, pending_n;
    logic          overrun_q, overrun_n;

    logic rx_m, rx_s;
    logic tick_q, tick_d, tick_en;

    // Line synchronizer resets to idle-high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            tick_q <= 1'b0;
            tick_d <= 1'b0;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            tick_q <= baud_sample_tick;
            tick_d <= tick_q;
        end
    end

    assign tick_en = tick_q & ~tick_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_byte_q  <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            pending    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_n;
            sample_cnt <= sample_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_reg_n;
            rx_byte_q  <= rx_byte_n;
            valid_q    <= valid_n;
            ferr_q     <= ferr_n;
            pending    <= pending_n;
            overrun_q  <= overrun_n;
        end
    end

    always_comb begin
        state_n      = state;
        sample_cnt_n = sample_cnt;
        bit_cnt_n    = bit_cnt;
        shift_reg_n  = shift_reg;
        rx_byte_n    = rx_byte_q;
        valid_n      = 1'b0;
        ferr_n       = 1'b0;
        pending_n    = pending;
        overrun_n    = overrun_q;

        if (bus.rd_ack) begin
            pending_n = 1'b0;
            overrun_n = 1'b0;
        end

        if (tick_en) begin
            unique case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_n      = S_START;
                        sample_cnt_n = '0;
                    end
                end
                S_START: begin
                    if (sample_cnt == HALF) begin
                        sample_cnt_n = '0;
                        bit_cnt_n    = '0;
                        state_n      = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        sample_cnt_n = sample_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (sample_cnt == LAST) begin
                        sample_cnt_n         = '0;
                        shift_reg_n[bit_cnt] = rx_s;
                        bit_cnt_n            = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = S_STOP;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (sample_cnt == LAST) begin
                        sample_cnt_n = '0;
                        if (rx_s) begin
                            rx_byte_n = shift_reg;
                            valid_n   = 1'b1;
                            pending_n = 1'b1;
                            // A coincident ack consumes the old byte first
                            if (pending && !bus.rd_ack) begin
                                overrun_n = 1'b1;
                            end
                            state_n = S_IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = S_BREAK;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_byte     = rx_byte_q;
    assign bus.rx_valid    = valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.overrun     = overrun_q;
    assign bus.rx_busy     = (state == S_DATA) || (state == S_STOP)
                           || (state == S_BREAK);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected bytes,
// tick every 4 clk, 16 ticks per bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [1:0] tick_ph = 2'd0;
    logic       baud_sample_tick;

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx               (rx),
        .baud_sample_tick (baud_sample_tick),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick_ph <= tick_ph + 2'd1;
    assign baud_sample_tick = tick_ph[1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int busy_cnt  = 0;
    int valid_cyc = 0;
    int start_cyc = 0;
    int lat, tgt, v0, f0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            if (exp_q.size() == 0) check("spurious_valid", 1, 0);
            else check("rx_byte", bus.rx_byte, exp_q.pop_front());
        end
        if (bus.frame_error) ferr_cnt++;
        if (bus.rx_busy) busy_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int stop_len);
        while (tick_ph != 2'd0) wait_cyc(1);
        rx = 1'b0;
        start_cyc = cyc;
        wait_cyc(64);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_cyc(64);
        end
        rx = stop;
        wait_cyc(64 * stop_len);
        rx = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.rd_ack = 1'b1;
        wait_cyc(1);
        bus.rd_ack = 1'b0;
    endtask

    initial begin
        bus.rd_ack = 1'b0;
        wait_cyc(5);
        check("rst_byte", bus.rx_byte, 8'h00);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_busy", bus.rx_busy, 0);
        check("rst_ferr", bus.frame_error, 0);
        check("rst_overrun", bus.overrun, 0);
        rst = 1'b1;
        wait_cyc(10);

        // Single frame 0xA5
        v0 = valid_cnt; f0 = ferr_cnt; busy_cnt = 0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1);
        wait_cyc(128);
        check("a5_valid_cnt", valid_cnt - v0, 1);
        check("a5_ferr_cnt", ferr_cnt - f0, 0);
        check("a5_busy_len", (busy_cnt >= 560 && busy_cnt <= 620), 1);
        check("a5_busy_end", bus.rx_busy, 0);
        ack_pulse();

        // Glitch in idle
        v0 = valid_cnt; f0 = ferr_cnt; busy_cnt = 0;
        rx = 1'b0;
        wait_cyc(20);
        rx = 1'b1;
        wait_cyc(200);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy", busy_cnt, 0);

        // Framing error, then recovery
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 4);
        wait_cyc(128);
        check("ferr_pulses", ferr_cnt - f0, 1);
        check("ferr_valid", valid_cnt - v0, 0);
        check("ferr_byte_kept", bus.rx_byte, 8'hA5);
        check("ferr_busy_end", bus.rx_busy, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1);
        wait_cyc(128);
        check("ferr_recover_valid", valid_cnt - v0, 1);
        check("ferr_recover_overrun", bus.overrun, 0);
        ack_pulse();

        // Back-to-back frames without ack
        v0 = valid_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 1);
        send_frame(8'hFF, 1'b1, 1);
        wait_cyc(128);
        check("b2b_valid_cnt", valid_cnt - v0, 2);
        check("b2b_byte", bus.rx_byte, 8'hFF);
        check("b2b_overrun", bus.overrun, 1);
        ack_pulse();
        check("b2b_overrun_clr", bus.overrun, 0);

        // Ack on the exact completion edge of the second frame
        v0 = valid_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1);
        wait_cyc(64);
        check("ack_first_valid", valid_cnt - v0, 1);
        lat = valid_cyc - start_cyc;
        exp_q.push_back(8'h22);
        start_cyc = -1;
        fork
            send_frame(8'h22, 1'b1, 1);
            begin
                wait (start_cyc >= 0);
                tgt = start_cyc + lat - 1;
                while (cyc < tgt) wait_cyc(1);
                bus.rd_ack = 1'b1;
                wait_cyc(1);
                bus.rd_ack = 1'b0;
            end
        join
        wait_cyc(64);
        check("ack_align", valid_cyc - start_cyc, lat);
        check("ack_overrun", bus.overrun, 0);
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, 1);
        wait_cyc(64);
        check("ack_pending", bus.overrun, 1);
        ack_pulse();

        // Reset in the middle of data bit 4
        v0 = valid_cnt; f0 = ferr_cnt;
        fork
            send_frame(8'h55, 1'b1, 1);
            begin
                wait_cyc(64 * 5 + 32);
                rst = 1'b0;
            end
        join
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(64);
        check("rst_mid_valid", valid_cnt - v0, 0);
        check("rst_mid_byte", bus.rx_byte, 8'h00);
        check("rst_mid_busy", bus.rx_busy, 0);
        check("rst_mid_overrun", bus.overrun, 0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1);
        wait_cyc(128);
        check("rst_after_valid", valid_cnt - v0, 1);
        check("rst_after_overrun", bus.overrun, 0);
        check("rst_after_ferr", ferr_cnt - f0, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
